// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm16bit command sequencer: state encoding,
// command field layout and small field-extraction helpers.
package fsm_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Command word layout: {rep[1:0], mode, direction, value[3:0]}
    localparam int CMD_W  = 8;
    localparam int REP_HI = 7;
    localparam int REP_LO = 6;
    localparam int MODE_B = 5;
    localparam int DIR_B  = 4;
    localparam int VAL_HI = 3;
    localparam int VAL_LO = 0;

    function automatic logic [1:0] cmd_rep(input logic [CMD_W-1:0] cmd);
        return cmd[REP_HI:REP_LO];
    endfunction

    function automatic logic cmd_mode(input logic [CMD_W-1:0] cmd);
        return cmd[MODE_B];
    endfunction

    function automatic logic cmd_dir(input logic [CMD_W-1:0] cmd);
        return cmd[DIR_B];
    endfunction

    function automatic logic [3:0] cmd_val(input logic [CMD_W-1:0] cmd);
        return cmd[VAL_HI:VAL_LO];
    endfunction

endpackage

// File: rtl/fsm16bit_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter. Purely combinational; the caller owns the
// pointer register. ptr names the requester that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       valid
);

    // One-hot grant: a lone request wins outright, a tie goes to ptr
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        valid = |req;
    end

endmodule

// File: rtl/fsm16bit_sequencer.sv
// Shares the fsm16bit shift/add datapath between two requesters. A winning
// command is latched and replayed as rep+1 single-cycle enable pulses, each
// followed by GAP_CYCLES enable-low cycles. All outputs are registered.
module fsm16bit_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [CMD_W-1:0] cmd0,
    input  logic             req1,
    input  logic [CMD_W-1:0] cmd1,
    input  logic             check_cfg,
    output logic             ack0,
    output logic             ack1,
    output logic             dp_enable,
    output logic             dp_mode,
    output logic             dp_direction,
    output logic [3:0]       dp_value,
    output logic             dp_check,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       gap_ctr_q, gap_ctr_d;
    logic [1:0]       rep_left_q, rep_left_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [3:0]       value_q, value_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             check_q, check_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    logic [1:0]       arb_grant;
    logic             arb_valid;
    logic [CMD_W-1:0] win_cmd;

    rr_arbiter2 u_arb (
        .req   ({req1, req0}),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign win_cmd = arb_grant[1] ? cmd1 : cmd0;

    // Next-state and next-output logic; outputs are derived from the next
    // state so that they line up with the state once registered.
    always_comb begin
        state_d     = state_q;
        gap_ctr_d   = gap_ctr_q;
        rep_left_d  = rep_left_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        value_d     = value_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        done_d      = 1'b0;
        issue_cnt_d = issue_cnt_q;
        check_d     = check_cfg;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = ISSUE;
                    owner_d    = arb_grant[1];
                    rep_left_d = cmd_rep(win_cmd);
                    mode_d     = cmd_mode(win_cmd);
                    dir_d      = cmd_dir(win_cmd);
                    value_d    = cmd_val(win_cmd);
                    ack0_d     = arb_grant[0];
                    ack1_d     = arb_grant[1];
                    // Pointer holds the tie-break winner, so hand it to the
                    // requester that just lost out.
                    rr_ptr_d   = ~arb_grant[1];
                end
            end
            ISSUE: begin
                state_d   = GAP;
                gap_ctr_d = GAP_LOAD;
            end
            GAP: begin
                if (gap_ctr_q == 4'd0) begin
                    if (rep_left_q != 2'd0) begin
                        rep_left_d = rep_left_q - 2'd1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_ctr_d = gap_ctr_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enable_d = (state_d == ISSUE);
        busy_d   = (state_d != IDLE);
        if (enable_d) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_ctr_q   <= '0;
            rep_left_q  <= '0;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            value_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            check_q     <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_ctr_q   <= gap_ctr_d;
            rep_left_q  <= rep_left_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            value_q     <= value_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            check_q     <= check_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign dp_enable    = enable_q;
    assign dp_mode      = mode_q;
    assign dp_direction = dir_q;
    assign dp_value     = value_q;
    assign dp_check     = check_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign owner        = owner_q;
    assign issue_count  = issue_cnt_q;

endmodule
